// File: rtl/seg_mux_display_if.sv
// User-side bundle for the multiplexed 7-segment driver: nibble/dp/enable inputs
// plus the board-facing segment, digit-select and frame-pulse outputs.
interface seg_mux_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] D;
  logic [NUM_DIGITS-1:0]   DP;
  logic [NUM_DIGITS-1:0]   EN;
  logic                    LOAD;
  logic                    LZ;
  logic [7:0]              SEG;
  logic [NUM_DIGITS-1:0]   DIGIT;
  logic                    FRAME;

  modport master (output D, DP, EN, LOAD, LZ, input  SEG, DIGIT, FRAME);
  modport slave  (input  D, DP, EN, LOAD, LZ, output SEG, DIGIT, FRAME);
endinterface

// File: rtl/seg_mux_display.sv
// N-digit common-anode 7-segment scanner: prescaled round-robin digit scan,
// frame-aligned double buffering, blank time and leading-zero suppression.
module seg_digit_lane (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       lz,
  input  logic       zero_hi,
  output logic [7:0] seg
);
  logic [6:0] pat;

  always_comb begin
    pat = 7'h00;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
  end

  // zero_hi means this nibble and every more-significant one are zero
  assign seg = {~dp, (lz && zero_hi) ? 7'h7F : ~pat};
endmodule

module seg_mux_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic             CLK,
  input  logic             RST,
  seg_mux_display_if.slave bus
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK   = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]                 cnt;
  logic [IW-1:0]                 idx;
  logic [NUM_DIGITS-1:0][3:0]    disp_d, pend_d;
  logic [NUM_DIGITS-1:0]         disp_dp, pend_dp;
  logic                          pend_valid;
  logic                          slot_end, fb, active;
  logic [NUM_DIGITS:1]           zero_above;
  logic [NUM_DIGITS-1:0][7:0]    lane_seg;
  logic [NUM_DIGITS-1:0]         onehot, digit_nx;
  logic [7:0]                    seg_nx;
  logic [7:0]                    seg_q;
  logic [NUM_DIGITS-1:0]         digit_q;
  logic                          frame_q;

  assign slot_end = (cnt == CNT_MAX);
  assign fb       = slot_end && (idx == IDX_MAX);

  // zero_above[k]: displayed nibbles k..NUM_DIGITS-1 are all zero
  assign zero_above[NUM_DIGITS] = 1'b1;
  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_zero
    assign zero_above[k] = zero_above[k+1] && (disp_d[k] == 4'd0);
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
    if (k == 0) begin : g_lsd
      seg_digit_lane u_lane (
        .nib(disp_d[k]), .dp(disp_dp[k]), .lz(bus.LZ),
        .zero_hi(1'b0), .seg(lane_seg[k])
      );
    end else begin : g_hi
      seg_digit_lane u_lane (
        .nib(disp_d[k]), .dp(disp_dp[k]), .lz(bus.LZ),
        .zero_hi(zero_above[k]), .seg(lane_seg[k])
      );
    end
  end

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
    active      = (cnt >= BLANK) && bus.EN[idx];
    digit_nx    = active ? ~onehot : '1;
    seg_nx      = active ? lane_seg[idx] : 8'hFF;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt        <= '0;
      idx        <= '0;
      disp_d     <= '0;
      disp_dp    <= '0;
      pend_d     <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      seg_q      <= 8'hFF;
      digit_q    <= '1;
      frame_q    <= 1'b0;
    end else begin
      cnt     <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      frame_q <= fb;
      seg_q   <= seg_nx;
      digit_q <= digit_nx;
      // display only changes on the frame boundary; a LOAD landing there wins
      if (fb) begin
        pend_valid <= 1'b0;
        if (bus.LOAD) begin
          disp_d  <= bus.D;
          disp_dp <= bus.DP;
        end else if (pend_valid) begin
          disp_d  <= pend_d;
          disp_dp <= pend_dp;
        end
      end else if (bus.LOAD) begin
        pend_d     <= bus.D;
        pend_dp    <= bus.DP;
        pend_valid <= 1'b1;
      end
    end
  end

  assign bus.SEG   = seg_q;
  assign bus.DIGIT = digit_q;
  assign bus.FRAME = frame_q;
endmodule

// File: tb/tb_seg_mux_display.sv
// Directed bench for seg_mux_display with 4 digits, 8-cycle slots, 2-cycle blank.
module tb_seg_mux_display;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   e = 0;

  seg_mux_display_if #(.NUM_DIGITS(4)) bus ();

  seg_mux_display #(.NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      e++;
    end
    #1;
  endtask

  task automatic goto(input int n);
    if (n > e) step(n - e);
  endtask

  // edge index whose sampled outputs show frame f, slot k, count c
  function automatic int at(input int f, input int k, input int c);
    return 32*f + 8*k + c + 1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic slot(input string tag, input int n, input logic [7:0] seg, input logic [3:0] dig);
    goto(n);
    chk({tag, "_seg"}, bus.SEG, seg);
    chk({tag, "_digit"}, {4'h0, bus.DIGIT}, {4'h0, dig});
  endtask

  initial begin
    bus.D = 16'h0; bus.DP = 4'b0; bus.EN = 4'hF; bus.LOAD = 1'b0; bus.LZ = 1'b0;

    // 1. reset and first slots
    step(3);
    chk("rst_seg", bus.SEG, 8'hFF);
    chk("rst_digit", {4'h0, bus.DIGIT}, 8'h0F);
    chk("rst_frame", {7'h0, bus.FRAME}, 8'h00);
    RST = 1'b0; e = 0;
    slot("blank1", 1, 8'hFF, 4'b1111);
    chk("frame_e1", {7'h0, bus.FRAME}, 8'h00);
    slot("blank2", 2, 8'hFF, 4'b1111);
    slot("first_d0", 3, 8'hC0, 4'b1110);
    slot("first_d1", 11, 8'hC0, 4'b1101);

    // 2. load 12AF, shown from the next frame
    bus.D = 16'h12AF; bus.DP = 4'b0100; bus.LOAD = 1'b1;
    step(1); bus.LOAD = 1'b0;
    goto(32); chk("frame_hi0", {7'h0, bus.FRAME}, 8'h01);
    goto(33); chk("frame_lo0", {7'h0, bus.FRAME}, 8'h00);
    slot("f1_blank", at(1,0,1), 8'hFF, 4'b1111);
    slot("f1_d0", at(1,0,4), 8'h8E, 4'b1110);
    slot("f1_d1", at(1,1,4), 8'h88, 4'b1101);
    slot("f1_d2", at(1,2,4), 8'h24, 4'b1011);
    slot("f1_d3", at(1,3,4), 8'hF9, 4'b0111);
    goto(64); chk("frame_hi1", {7'h0, bus.FRAME}, 8'h01);

    // 3. last pending load wins; load on fb goes straight to display
    bus.D = 16'h1111; bus.LOAD = 1'b1; step(1);
    bus.D = 16'h2222; step(1); bus.LOAD = 1'b0;
    slot("f2_old", at(2,0,4), 8'h8E, 4'b1110);
    slot("f3_d0", at(3,0,4), 8'hA4, 4'b1110);
    slot("f3_d2", at(3,2,4), 8'h24, 4'b1011);
    slot("f3_late", 127, 8'hA4, 4'b0111);
    bus.D = 16'h3333; bus.LOAD = 1'b1; step(1); bus.LOAD = 1'b0;
    slot("f4_d0", at(4,0,4), 8'hB0, 4'b1110);
    slot("f4_d2", at(4,2,4), 8'h30, 4'b1011);

    // 4. leading-zero suppression
    bus.D = 16'h0050; bus.DP = 4'b0; bus.LZ = 1'b1; bus.LOAD = 1'b1;
    step(1); bus.LOAD = 1'b0;
    slot("lz_d0", at(5,0,4), 8'hC0, 4'b1110);
    slot("lz_d1", at(5,1,4), 8'h92, 4'b1101);
    slot("lz_d2", at(5,2,4), 8'hFF, 4'b1011);
    slot("lz_d3", at(5,3,4), 8'hFF, 4'b0111);
    bus.D = 16'h0000; bus.LOAD = 1'b1; step(1); bus.LOAD = 1'b0;
    slot("lz0_d0", at(6,0,4), 8'hC0, 4'b1110);
    slot("lz0_d1", at(6,1,4), 8'hFF, 4'b1101);
    slot("lz0_d2", at(6,2,4), 8'hFF, 4'b1011);

    // 5. per-digit enable
    bus.LZ = 1'b0; bus.EN = 4'b1010;
    slot("en_d0", at(7,0,4), 8'hFF, 4'b1111);
    slot("en_d1", at(7,1,4), 8'hC0, 4'b1101);
    slot("en_d2", at(7,2,4), 8'hFF, 4'b1111);
    slot("en_d3", at(7,3,4), 8'hC0, 4'b0111);

    // 6. reset mid-slot discards pending and restarts the scan
    bus.EN = 4'hF; bus.D = 16'hABCD; bus.LOAD = 1'b1; step(1); bus.LOAD = 1'b0;
    goto(at(8,2,2));
    RST = 1'b1; step(1);
    chk("rst2_seg", bus.SEG, 8'hFF);
    chk("rst2_digit", {4'h0, bus.DIGIT}, 8'h0F);
    chk("rst2_frame", {7'h0, bus.FRAME}, 8'h00);
    RST = 1'b0; e = 0;
    slot("rst2_blank", 2, 8'hFF, 4'b1111);
    slot("rst2_d0", 3, 8'hC0, 4'b1110);
    goto(32); chk("rst2_frame_hi", {7'h0, bus.FRAME}, 8'h01);
    slot("rst2_nopend", at(1,0,4), 8'hC0, 4'b1110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_mux_display.md
Name: seg_mux_display

Overview:
Parametrised multiplexed driver for an N-digit common-anode 7-segment display, successor to the single-digit fixed-select test top. Scans the digits round-robin at a prescaled refresh rate, decodes a 4-bit hex nibble per digit, and drives a decimal point and per-digit enable. Adds a tear-free double-buffered load, anti-ghosting blank time and leading-zero suppression. Sits between user logic and the board SEG/DIGIT pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
CLK_DIV, 1000, CLK cycles per digit slot (>=2)
BLANK_CYCLES, 50, cycles at start of each slot with all digits off (0..CLK_DIV-1)

Ports:
CLK  input  1  system clock
RST  input  1  synchronous, active-high reset
D  input  4*NUM_DIGITS  hex nibbles; D[4k+3:4k] = digit k, digit 0 = least significant
DP  input  NUM_DIGITS  decimal point request per digit, 1 = lit
EN  input  NUM_DIGITS  per-digit enable, 0 = digit held dark
LOAD  input  1  capture D/DP into pending buffer
LZ  input  1  leading-zero suppression enable
SEG  output  8  segments, active-low; SEG[0..6] = a..g, SEG[7] = dp
DIGIT  output  NUM_DIGITS  digit selects, active-low, at most one low
FRAME  output  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (RST=1 at a CLK edge): cnt=0, idx=0, display and pending buffers=0, pend_valid=0; SEG=8'hFF, DIGIT=all 1s, FRAME=0. Reset mid-scan aborts immediately; there is no partial-frame carryover. EN, LZ, DP and D are sampled only as defined below.
- Prescaler: cnt counts 0..CLK_DIV-1 and wraps. When cnt==CLK_DIV-1, idx advances: idx+1, or 0 after NUM_DIGITS-1.
- Frame boundary (fb) = cnt==CLK_DIV-1 and idx==NUM_DIGITS-1. FRAME=1 for exactly the cycle after fb (registered).
- Buffering: LOAD with no fb -> pending<=D/DP, pend_valid<=1; repeated LOADs overwrite (last wins). At fb: LOAD=1 -> display<=D/DP directly and pend_valid<=0; else pend_valid=1 -> display<=pending and pend_valid<=0; else display is unchanged. The displayed value changes only between frames.
- Outputs are registered. SEG and DIGIT in cycle t+1 reflect the cnt/idx/display state in cycle t (1-cycle latency).
- DIGIT[k]=0 iff idx==k, cnt>=BLANK_CYCLES and EN[k]=1; otherwise 1. During blank time or a disabled slot, DIGIT is all 1s and SEG=8'hFF.
- Decode (active-high gfedcba before inversion): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. SEG[6:0] = ~pattern. SEG[7] = ~display_dp[idx].
- Leading-zero suppression: with LZ=1, digit k>0 is suppressed if display nibbles k..NUM_DIGITS-1 are all 0. A suppressed digit has SEG[6:0]=7'h7F, and its dp still follows DP. Digit 0 is never suppressed. LZ is sampled live, not buffered.
- NUM_DIGITS=1: idx is constant 0, and fb occurs every CLK_DIV cycles.

Test Plan:
(Bench uses NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.)
1. Reset hold, then release -> SEG=FF, DIGIT=1111, FRAME=0 until the first active slot. DIGIT=1110 appears first at cycle 3 after release (cnt=2 plus 1 latency). Digit 1 select follows 8 cycles later.
2. LOAD D=16'h12AF, DP=4'b0100, EN=1111, LZ=0, then wait for the next frame -> slots show SEG FF^71=8E (F), 88 (A), 24 with SEG[7]=0 for digit 2 (2 + dp), F9 (1). FRAME pulses every 32 cycles.
3. LOAD 16'h1111 mid-frame, then LOAD 16'h2222 before fb -> the current frame still shows the old value, and the next frame shows 2222 only. LOAD exactly on the fb cycle with 16'h3333 -> the next frame shows 3333.
4. D=16'h0050, LZ=1 -> digits 3,2 suppressed (SEG=FF, DIGIT still low in slot), digit 1 shows 92 (5), digit 0 shows C0 (0). D=16'h0000 -> only digit 0 shows C0.
5. EN=4'b1010 -> DIGIT never goes low in slots 0 and 2, and SEG=FF there. Slots 1 and 3 behave normally.
6. Assert RST for 1 cycle mid-slot 2 -> next cycle outputs are at reset values, display=0, a pending LOAD is discarded, and the scan restarts at idx=0, cnt=0.
